// File: rtl/ram_arb.sv
// ram_arb: N-channel request/grant arbiter in front of one single-port byte-write RAM.
// Fixed-priority or round-robin selection, address-window check and one-cycle read return.
module ram_arb #(
  parameter int              XLEN = 32,
  parameter int              NCH  = 3,
  parameter int              AW   = 15,
  parameter logic [XLEN-1:0] BASE = 32'h0002_0000,
  parameter bit              RR   = 1'b1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [NCH-1:0]        req_i,
  input  logic [NCH-1:0]        we_i,
  input  logic [NCH*XLEN-1:0]   addr_i,
  input  logic [NCH*XLEN-1:0]   wdata_i,
  input  logic [NCH*XLEN/8-1:0] be_i,
  output logic [NCH-1:0]        gnt_o,
  output logic [NCH-1:0]        rvalid_o,
  output logic [XLEN-1:0]       rdata_o,
  output logic [7:0]            rbyte_o,
  output logic [NCH-1:0]        err_o,
  output logic                  mem_en_o,
  output logic [XLEN/8-1:0]     mem_we_o,
  output logic [AW-1:0]         mem_addr_o,
  output logic [XLEN-1:0]       mem_wdata_o,
  input  logic [XLEN-1:0]       mem_rdata_i
);

  localparam int BW = XLEN / 8;
  localparam int PW = (NCH > 1) ? $clog2(NCH) : 1;

  logic [PW-1:0]   ptr_q, ptr_d;
  logic [PW:0]     idx_s;
  logic [PW-1:0]   gidx_s;
  logic            any_s;
  logic [NCH-1:0]  gnt_s;
  logic [XLEN-1:0] a_s, wd_s;
  logic [BW-1:0]   be_s;
  logic            we_s, inwin_s;
  logic [NCH-1:0]  rvalid_q, rvalid_d, err_q, err_d;
  logic            pend_q, pend_d, oow_q, oow_d;
  logic [1:0]      off_q, off_d;
  logic [XLEN-1:0] rdata_q, rdata_s;
  logic [7:0]      rbyte_q, rbyte_s;

  // Scan the requesters starting at the pointer (or at 0 for fixed priority); first hit wins.
  always_comb begin
    idx_s  = {(PW+1){1'b0}};
    gidx_s = {PW{1'b0}};
    any_s  = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      idx_s = (RR ? {1'b0, ptr_q} : {(PW+1){1'b0}}) + (PW+1)'(i);
      if (idx_s >= (PW+1)'(NCH)) begin
        idx_s = idx_s - (PW+1)'(NCH);
      end else begin
        idx_s = idx_s;
      end
      if (!any_s && req_i[idx_s] && !rst_i) begin
        any_s  = 1'b1;
        gidx_s = idx_s[PW-1:0];
      end else begin
        any_s  = any_s;
      end
    end
    gnt_s = {{(NCH-1){1'b0}}, any_s} << gidx_s;
  end

  assign a_s     = addr_i[int'(gidx_s)*XLEN +: XLEN];
  assign wd_s    = wdata_i[int'(gidx_s)*XLEN +: XLEN];
  assign be_s    = be_i[int'(gidx_s)*BW +: BW];
  assign we_s    = we_i[gidx_s];
  assign inwin_s = (a_s[XLEN-1:AW+2] == BASE[XLEN-1:AW+2]);

  // RAM-side strobes follow the grant in the same cycle.
  always_comb begin
    mem_en_o    = any_s & inwin_s;
    mem_addr_o  = a_s[AW+1:2];
    mem_wdata_o = wd_s;
    if (any_s && inwin_s && we_s) begin
      mem_we_o = be_s;
    end else begin
      mem_we_o = {BW{1'b0}};
    end
  end

  // Next-state for the pointer and the read/error response pipeline.
  always_comb begin
    ptr_d    = ptr_q;
    rvalid_d = {NCH{1'b0}};
    err_d    = {NCH{1'b0}};
    pend_d   = 1'b0;
    oow_d    = oow_q;
    off_d    = off_q;
    if (any_s) begin
      if (gidx_s == PW'(NCH - 1)) begin
        ptr_d = {PW{1'b0}};
      end else begin
        ptr_d = gidx_s + PW'(1);
      end
      if (!we_s) begin
        rvalid_d = gnt_s;
        pend_d   = 1'b1;
        oow_d    = ~inwin_s;
        off_d    = a_s[1:0];
      end else begin
        pend_d   = 1'b0;
      end
      if (!inwin_s) begin
        err_d = gnt_s;
      end else begin
        err_d = {NCH{1'b0}};
      end
    end else begin
      ptr_d = ptr_q;
    end
  end

  // Out-of-window reads return zero; otherwise pass the RAM word and hold it afterwards.
  always_comb begin
    rdata_s = rdata_q;
    rbyte_s = rbyte_q;
    if (pend_q) begin
      if (oow_q) begin
        rdata_s = {XLEN{1'b0}};
      end else begin
        rdata_s = mem_rdata_i;
      end
      case (off_q)
        2'd0:    rbyte_s = rdata_s[7:0];
        2'd1:    rbyte_s = rdata_s[15:8];
        2'd2:    rbyte_s = rdata_s[23:16];
        2'd3:    rbyte_s = rdata_s[31:24];
        default: rbyte_s = 8'h00;
      endcase
    end else begin
      rdata_s = rdata_q;
    end
  end

  // State registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ptr_q    <= {PW{1'b0}};
      rvalid_q <= {NCH{1'b0}};
      err_q    <= {NCH{1'b0}};
      pend_q   <= 1'b0;
      oow_q    <= 1'b0;
      off_q    <= 2'd0;
      rdata_q  <= {XLEN{1'b0}};
      rbyte_q  <= 8'h00;
    end else begin
      ptr_q    <= ptr_d;
      rvalid_q <= rvalid_d;
      err_q    <= err_d;
      pend_q   <= pend_d;
      oow_q    <= oow_d;
      off_q    <= off_d;
      rdata_q  <= rdata_s;
      rbyte_q  <= rbyte_s;
    end
  end

  assign gnt_o    = gnt_s;
  assign rvalid_o = rvalid_q;
  assign err_o    = err_q;
  assign rdata_o  = rdata_s;
  assign rbyte_o  = rbyte_s;

endmodule

// File: tb/tb_ram_arb.sv
// Self-checking bench for ram_arb: a round-robin and a fixed-priority instance share stimulus;
// a behavioural RAM and a word-level scoreboard predict grants, strobes and read responses.
module tb_ram_arb;
  localparam logic [31:0] BASE = 32'h0002_0000;
  localparam logic [31:0] WSPAN = 32'h0002_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  req, we;
  logic [31:0] addr [3];
  logic [31:0] wdata [3];
  logic [3:0]  be [3];
  logic [95:0] addr_bus, wdata_bus;
  logic [11:0] be_bus;

  logic [2:0]  gnt, rvalid, err;
  logic [31:0] rdata, mem_wdata, mem_rdata;
  logic [7:0]  rbyte;
  logic        mem_en;
  logic [3:0]  mem_we;
  logic [14:0] mem_addr;

  logic [2:0]  fp_gnt, fp_rvalid, fp_err;
  logic [31:0] fp_rdata, fp_mem_wdata;
  logic [7:0]  fp_rbyte;
  logic        fp_mem_en;
  logic [3:0]  fp_mem_we;
  logic [14:0] fp_mem_addr;

  logic [31:0] ram [0:32767];

  int          total = 0;
  int          bad = 0;
  int          ptr_m = 0;
  int          rv_count = 0;
  logic [31:0] mem_m [int];
  logic [2:0]  exp_rvalid = 3'b000, exp_err = 3'b000;
  logic [31:0] exp_rdata = 32'h0;
  logic [7:0]  exp_rbyte = 8'h0;
  logic [2:0]  last_gnt, last_fp_gnt;

  assign addr_bus  = {addr[2], addr[1], addr[0]};
  assign wdata_bus = {wdata[2], wdata[1], wdata[0]};
  assign be_bus    = {be[2], be[1], be[0]};

  always #5 clk = ~clk;

  ram_arb #(.RR(1'b1)) u_dut (
    .clk_i(clk), .rst_i(rst), .req_i(req), .we_i(we), .addr_i(addr_bus),
    .wdata_i(wdata_bus), .be_i(be_bus), .gnt_o(gnt), .rvalid_o(rvalid),
    .rdata_o(rdata), .rbyte_o(rbyte), .err_o(err), .mem_en_o(mem_en),
    .mem_we_o(mem_we), .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
    .mem_rdata_i(mem_rdata)
  );

  ram_arb #(.RR(1'b0)) u_fp (
    .clk_i(clk), .rst_i(rst), .req_i(req), .we_i(we), .addr_i(addr_bus),
    .wdata_i(wdata_bus), .be_i(be_bus), .gnt_o(fp_gnt), .rvalid_o(fp_rvalid),
    .rdata_o(fp_rdata), .rbyte_o(fp_rbyte), .err_o(fp_err), .mem_en_o(fp_mem_en),
    .mem_we_o(fp_mem_we), .mem_addr_o(fp_mem_addr), .mem_wdata_o(fp_mem_wdata),
    .mem_rdata_i(32'h0)
  );

  // Synchronous single-port RAM with byte writes, one-cycle read latency.
  always @(posedge clk) begin
    if (mem_en) begin
      for (int b = 0; b < 4; b++)
        if (mem_we[b]) ram[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
      mem_rdata <= ram[mem_addr];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  function automatic logic [2:0] pick(input logic [2:0] r, input int start);
    for (int n = 0; n < 3; n++)
      if (r[(start + n) % 3]) return 3'b001 << ((start + n) % 3);
    return 3'b000;
  endfunction

  function automatic logic [31:0] rd_m(input int w);
    if (mem_m.exists(w)) return mem_m[w];
    return 32'h0;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] b);
    logic [31:0] r;
    r = old;
    for (int n = 0; n < 4; n++)
      if (b[n]) r = (r & ~(32'hFF << (8*n))) | (d & (32'hFF << (8*n)));
    return r;
  endfunction

  task automatic clr();
    req = 3'b000;
    we  = 3'b000;
    for (int n = 0; n < 3; n++) begin
      addr[n] = BASE; wdata[n] = 32'h0; be[n] = 4'h0;
    end
  endtask

  task automatic setch(input int k, input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] b);
    req[k] = 1'b1; we[k] = w; addr[k] = a; wdata[k] = d; be[k] = b;
  endtask

  // One bus cycle: check grant/strobes mid-cycle, then the registered response after the edge.
  task automatic step();
    logic [2:0]  g;
    int          k;
    logic        inwin;
    logic [31:0] a;
    int          w;
    @(negedge clk);
    g = pick(req, ptr_m);
    last_gnt = gnt;
    last_fp_gnt = fp_gnt;
    chk("gnt", gnt, g);
    chk("fp_gnt", fp_gnt, pick(req, 0));
    exp_rvalid = 3'b000;
    exp_err = 3'b000;
    if (g != 3'b000) begin
      k = 0;
      for (int n = 0; n < 3; n++) if (g[n]) k = n;
      a = addr[k];
      inwin = (a >= BASE) && (a < BASE + WSPAN);
      chk("mem_en", mem_en, inwin);
      w = 0;
      if (inwin) begin
        w = int'((a - BASE) >> 2);
        chk("mem_addr", mem_addr, w);
        chk("mem_we", mem_we, we[k] ? be[k] : 4'h0);
        if (we[k]) chk("mem_wdata", mem_wdata, wdata[k]);
      end else begin
        exp_err = g;
      end
      if (!we[k]) begin
        exp_rvalid = g;
        exp_rdata = inwin ? rd_m(w) : 32'h0;
        exp_rbyte = 8'(exp_rdata >> (8 * (a % 4)));
      end else if (inwin) begin
        mem_m[w] = merge(rd_m(w), wdata[k], be[k]);
      end
      ptr_m = (k + 1) % 3;
    end else begin
      chk("mem_en_idle", mem_en, 1'b0);
    end
    @(posedge clk);
    #1;
    chk("rvalid", rvalid, exp_rvalid);
    chk("err", err, exp_err);
    chk("rdata", rdata, exp_rdata);
    chk("rbyte", rbyte, exp_rbyte);
    if (rvalid != 3'b000) rv_count++;
  endtask

  initial begin
    #1000000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    for (int n = 0; n < 32768; n++) ram[n] = 32'h0;
    mem_rdata = 32'h0;
    clr();
    rst = 1'b1;
    req = 3'b111;
    #12;
    chk("rst_gnt", gnt, 3'b000);
    chk("rst_mem_en", mem_en, 1'b0);
    chk("rst_rvalid", rvalid, 3'b000);
    chk("rst_err", err, 3'b000);
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_rbyte", rbyte, 8'h0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Round-robin rotation with all three requesting, then fixed priority with 3'b110.
    clr();
    for (int n = 0; n < 3; n++) setch(n, 1'b0, BASE + 32'(16 * n), 32'h0, 4'h0);
    for (int i = 0; i < 6; i++) begin
      step();
      chk("rr_seq", last_gnt, 3'b001 << (i % 3));
    end
    req[0] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("fp_seq", last_fp_gnt, 3'b010);
    end

    // Write with partial byte enables, read back, then a misaligned byte read and a hold cycle.
    clr(); setch(0, 1'b1, 32'h0002_0010, 32'hDEAD_BEEF, 4'b0101); step();
    clr(); setch(0, 1'b0, 32'h0002_0010, 32'h0, 4'h0); step();
    chk("wr_rd_word", rdata, 32'h00AD_00EF);
    clr(); setch(0, 1'b0, 32'h0002_0012, 32'h0, 4'h0); step();
    chk("wr_rd_byte", rbyte, 8'hAD);
    clr(); step();
    chk("hold_rdata", rdata, 32'h00AD_00EF);

    // Out-of-window read and write on channel 1; RAM word 0 must stay untouched.
    clr(); setch(1, 1'b0, 32'h0004_0000, 32'h0, 4'h0); step();
    chk("oow_rvalid", rvalid, 3'b010);
    chk("oow_err", err, 3'b010);
    chk("oow_rdata", rdata, 32'h0);
    clr(); setch(1, 1'b1, 32'h0004_0000, 32'hFFFF_FFFF, 4'hF); step();
    chk("oow_wr_err", err, 3'b010);
    clr(); setch(1, 1'b0, 32'h0002_0000, 32'h0, 4'h0); step();
    chk("oow_wr_dropped", rdata, 32'h0);

    // Throughput: prefill, then 16 gap-free alternating reads from channels 0 and 2.
    for (int i = 0; i < 8; i++) begin
      clr(); setch(0, 1'b1, BASE + 32'h100 + 32'(4 * i), $urandom, 4'hF); step();
    end
    rv_count = 0;
    for (int i = 0; i < 16; i++) begin
      clr();
      setch((i % 2) * 2, 1'b0, BASE + 32'h100 + 32'(4 * (i % 8)) + 32'(i % 4), 32'h0, 4'h0);
      step();
    end
    chk("tput_cnt", rv_count, 16);

    // Randomised traffic, mostly in-window with occasional out-of-window accesses.
    for (int i = 0; i < 300; i++) begin
      clr();
      for (int n = 0; n < 3; n++) begin
        req[n] = 1'($urandom);
        we[n]  = 1'($urandom);
        if ($urandom_range(0, 7) == 0) addr[n] = 32'h0004_0000 + 32'($urandom_range(0, 255));
        else addr[n] = BASE + 32'($urandom_range(0, 63) << 2) + 32'($urandom_range(0, 3));
        wdata[n] = $urandom;
        be[n]    = 4'($urandom_range(0, 15));
      end
      step();
    end

    // Reset in the middle of a read: the grant is seen, the response never arrives.
    clr(); setch(0, 1'b0, BASE, 32'h0, 4'h0); step();
    clr(); setch(1, 1'b0, BASE + 32'h100, 32'h0, 4'h0);
    @(negedge clk);
    chk("rst_mid_gnt", gnt, 3'b010);
    #1 rst = 1'b1;
    #1;
    chk("rst_mid_gnt0", gnt, 3'b000);
    chk("rst_mid_mem_en", mem_en, 1'b0);
    chk("rst_mid_rvalid", rvalid, 3'b000);
    chk("rst_mid_rdata", rdata, 32'h0);
    chk("rst_mid_rbyte", rbyte, 8'h0);
    chk("rst_mid_err", err, 3'b000);
    @(posedge clk); #1;
    chk("rst_mid_no_rvalid", rvalid, 3'b000);
    @(negedge clk);
    rst = 1'b0;
    clr();
    ptr_m = 0; exp_rdata = 32'h0; exp_rbyte = 8'h0;
    step();
    clr();
    for (int n = 0; n < 3; n++) setch(n, 1'b0, BASE + 32'(8 * n), 32'h0, 4'h0);
    step();
    chk("rst_ptr_home", last_gnt, 3'b001);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
